// File: rtl/mips_instr_encoder.sv
// Program-load encoder: turns field-level instruction requests into 32-bit MIPS
// words and writes them sequentially into the instruction-memory write port.
module mips_instr_encoder #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                DEPTH     = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_cls,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [5:0]        in_funct,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [6:0]        word_count,
  output logic              done,
  output logic              err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [6:0] DEPTH_C = 7'(DEPTH);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]       imem_wdata_q, imem_wdata_d;
  logic [6:0]        word_count_q, word_count_d;
  logic              err_q, err_d;
  logic              accept;
  logic              full;

  function automatic logic [31:0] encode(
    input logic [2:0]  cls,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [4:0]  shamt,
    input logic [5:0]  funct,
    input logic [15:0] imm,
    input logic [25:0] target
  );
    logic [31:0] w;
    case (cls)
      3'd0:    w = {6'b000000, rs, rt, rd, shamt, funct};
      3'd1:    w = {6'b100011, rs, rt, imm};
      3'd2:    w = {6'b101011, rs, rt, imm};
      3'd3:    w = {6'b000100, rs, rt, imm};
      3'd4:    w = {6'b001000, rs, rt, imm};
      3'd5:    w = {6'b000010, target};
      default: w = '0;
    endcase
    return w;
  endfunction

  assign full     = (word_count_q == DEPTH_C);
  assign in_ready = (state_q == ST_LOAD) && (word_count_q < DEPTH_C);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    word_count_d = word_count_q;
    err_d        = err_q;
    case (state_q)
      ST_LOAD: begin
        if (accept) begin
          // Classes 6-7 are consumed without a write so the stream never stalls.
          if (in_cls <= 3'd5) begin
            imem_we_d    = 1'b1;
            imem_addr_d  = ptr_q;
            imem_wdata_d = encode(in_cls, in_rs, in_rt, in_rd, in_shamt,
                                  in_funct, in_imm, in_target);
            ptr_d        = ptr_q + ADDR_W'(4);
            word_count_d = word_count_q + 7'd1;
          end else begin
            err_d = 1'b1;
          end
          if (in_last) state_d = ST_DONE;
        end else if (in_valid && full) begin
          err_d = 1'b1;
        end
      end
      default: begin
        if (start) begin
          state_d      = ST_LOAD;
          ptr_d        = BASE_ADDR;
          word_count_d = '0;
          err_d        = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ptr_q        <= BASE_ADDR;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= BASE_ADDR;
      imem_wdata_q <= '0;
      word_count_q <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      word_count_q <= word_count_d;
      err_q        <= err_d;
    end
  end

  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign word_count = word_count_q;
  assign done       = (state_q == ST_DONE);
  assign err        = err_q;

endmodule

// File: doc/mips_instr_encoder.md
Name: mips_instr_encoder

Overview:
Program-load block that produces instructions for the single-cycle core: the encoding end of the opcode/field format that the control path decodes. It accepts field-level instruction requests over a valid/ready handshake and assembles 32-bit MIPS words. It writes them sequentially into the instruction-memory write port before the core is released from reset. It supports exactly the instruction set the core's control decodes: R-type, LW, SW, BEQ, ADDI, J.

Parameters:
ADDR_W, 32, width of instruction-memory byte address
BASE_ADDR, 32'h0000_0000, byte address of the first written word
DEPTH, 64, maximum number of words written per load session

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; opens a load session
in_valid  in  1  request valid
in_ready  out  1  block can accept a request this cycle
in_cls  in  3  class: 0 R, 1 LW, 2 SW, 3 BEQ, 4 ADDI, 5 J, 6-7 illegal
in_rs  in  5  rs field
in_rt  in  5  rt field
in_rd  in  5  rd field (R only)
in_shamt  in  5  shamt (R only)
in_funct  in  6  funct (R only)
in_imm  in  16  immediate (LW/SW/BEQ/ADDI)
in_target  in  26  jump target (J only)
in_last  in  1  final request of the session
imem_we  out  1  instruction-memory write strobe
imem_addr  out  ADDR_W  byte write address
imem_wdata  out  32  encoded instruction word
word_count  out  7  words written this session
done  out  1  session complete (level)
err  out  1  sticky: illegal class or overflow seen this session

Behaviour:
- Reset, applied synchronously: state IDLE, in_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, word_count=0, done=0, err=0. Reset mid-session abandons it; no further writes.
- FSM states: IDLE, LOAD, DONE.
  - IDLE -> LOAD on start.
  - LOAD -> DONE when a request with in_last=1 is accepted.
  - DONE -> LOAD on start.
  - start is ignored in LOAD.
- Entering LOAD from IDLE or DONE clears word_count, err and done, and sets the write pointer to BASE_ADDR.
- in_ready = (state==LOAD) && (word_count < DEPTH). A request is accepted when in_valid && in_ready. Inputs are sampled on the accept edge.
- Latency: one cycle. On the cycle after an accept, imem_we=1 with the registered word and address. imem_we is 0 otherwise. Back-to-back accepts give one write per cycle.
- Encoding, MSB first:
  - R: 000000, rs, rt, rd, shamt, funct.
  - LW: 100011, rs, rt, imm.
  - SW: 101011, rs, rt, imm.
  - BEQ: 000100, rs, rt, imm.
  - ADDI: 001000, rs, rt, imm.
  - J: 000010, target.
  - Fields not used by a class are ignored.
- After each write, the pointer advances by 4. word_count increments by 1 on the same edge as the write. The address wraps modulo 2^ADDR_W with no special handling.
- Illegal class (6-7): accepted, but no write, no pointer or count change, err<=1. If in_last=1, the FSM still goes to DONE.
- Full (word_count==DEPTH while in LOAD): in_ready=0. If in_valid is held high for one cycle while full, err<=1. The FSM stays in LOAD until start or reset. There is no implicit DONE.
- done=1 exactly while in DONE. It rises on the same edge as the final write's imem_we. err and word_count hold in DONE.

Test Plan:
- Reset, start, then R rs=8 rt=9 rd=10 shamt=0 funct=0x20 with last=1 -> next cycle imem_we=1, addr=0x0, wdata=0x01095020; then done=1, word_count=1.
- Back-to-back LW rs=16 rt=8 imm=4; SW rs=29 rt=8 imm=0; BEQ rs=1 rt=2 imm=0xFFFF; ADDI rs=0 rt=8 imm=5; J target=0x40 (last) -> consecutive writes 0x8E080004@0x0, 0xAFA80000@0x4, 0x1022FFFF@0x8, 0x20080005@0xC, 0x08000040@0x10; word_count=5.
- Hold in_valid=1 with in_cls=6 between two ADDIs -> only 2 writes, at 0x0 and 0x4; err=1.
- Send DEPTH=64 valid non-last requests -> 64 writes, last at 0xFC; in_ready=0; further in_valid sets err=1; no 65th write.
- Assert rst during a session after 3 writes -> outputs take reset values; a new start writes from BASE_ADDR with word_count=1 after the first write.
- Toggle in_valid randomly and pulse start while in LOAD -> start ignored, no dropped or duplicated writes, and addresses strictly sequential.
